// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_pkg : shared types and constants for the fetch stage    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [1:0]  MEM_WORD         = 2'b10;

  typedef enum logic [1:0] {
    FS_REQ    = 2'd0,
    FS_WAIT   = 2'd1,
    FS_HOLD   = 2'd2,
    FS_CANCEL = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        delayslot;
  } hold_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_hold_buf : single-entry buffer parking a fetched word while   |
// | decode is stalled.  Rev 1.0                                         |
// +--------------------------------------------------------------------+
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  hold_entry_t wr_data,
  output hold_entry_t rd_data
);

  hold_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (wr_en) entry_d = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  assign rd_data = entry_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : MIPS IF stage, one outstanding SRAM-like request,     |
// | decode-stall buffering, delay-slot redirect, flush.  Rev 1.0        |
// +--------------------------------------------------------------------+
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        is_branchD,
  input  logic        redirectD,
  input  logic [31:0] redirect_pcD,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        adelD,
  output logic        delayslotD
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         ds_q, ds_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic         id_valid_q, id_valid_d;
  logic         id_adel_q, id_adel_d;
  logic         id_ds_q, id_ds_d;

  logic         aligned, ds_now, advance, hold_wr;
  logic [31:0]  next_pc;
  hold_entry_t  hold_wdata, hold_rdata;

  assign aligned    = (pc_q[1:0] == 2'b00);
  // A branch seen in D at any point during this fetch marks the word as its delay slot.
  assign ds_now     = ds_q | is_branchD;
  assign next_pc    = redirectD ? redirect_pcD : (pend_q ? pend_pc_q : pc_q + 32'd4);
  assign inst_req   = ~rst & (state_q == FS_REQ) & aligned;
  assign hold_wdata = '{instr: inst_rdata, pc: pc_q, delayslot: ds_now};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q | redirectD;
    pend_pc_d  = redirectD ? redirect_pcD : pend_pc_q;
    ds_d       = ds_now;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    id_ds_d    = id_ds_q;
    hold_wr    = 1'b0;
    advance    = 1'b0;

    if (!stallD) begin
      id_instr_d = '0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
      id_ds_d    = 1'b0;
    end

    case (state_q)
      FS_REQ: begin
        if (aligned) begin
          if (inst_addr_ok) state_d = FS_WAIT;
        end else if (!stallD) begin
          id_instr_d = '0;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          id_adel_d  = 1'b1;
          id_ds_d    = ds_now;
          advance    = 1'b1;
        end
      end
      FS_WAIT: begin
        if (inst_data_ok) begin
          if (!stallD) begin
            id_instr_d = inst_rdata;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            id_ds_d    = ds_now;
            advance    = 1'b1;
          end else begin
            hold_wr = 1'b1;
            state_d = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (!stallD) begin
          id_instr_d = hold_rdata.instr;
          id_pc_d    = hold_rdata.pc;
          id_valid_d = 1'b1;
          id_ds_d    = hold_rdata.delayslot;
          advance    = 1'b1;
        end
      end
      FS_CANCEL: begin
        if (inst_data_ok) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase

    if (advance) begin
      pc_d    = next_pc;
      pend_d  = 1'b0;
      ds_d    = 1'b0;
      state_d = FS_REQ;
    end

    // Flush wins over everything; an accepted-but-unanswered request must be drained.
    if (flush) begin
      pc_d       = flush_pc;
      pend_d     = 1'b0;
      ds_d       = 1'b0;
      id_instr_d = '0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
      id_ds_d    = 1'b0;
      case (state_q)
        FS_REQ:            state_d = (inst_req && inst_addr_ok) ? FS_CANCEL : FS_REQ;
        FS_WAIT, FS_CANCEL: state_d = inst_data_ok ? FS_REQ : FS_CANCEL;
        default:           state_d = FS_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_REQ;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      ds_q       <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
      id_ds_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      ds_q       <= ds_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
      id_ds_q    <= id_ds_d;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hold_wr),
    .wr_data (hold_wdata),
    .rd_data (hold_rdata)
  );

  assign inst_wr    = 1'b0;
  assign inst_size  = MEM_WORD;
  assign inst_addr  = pc_q;
  assign inst_wdata = '0;
  assign instrD     = id_instr_q;
  assign pcD        = id_pc_q;
  assign validD     = id_valid_q;
  assign adelD      = id_adel_q;
  assign delayslotD = id_ds_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage : scoreboard bench for fetch_stage with a simple     |
// | instruction-bridge responder.  Rev 1.0                              |
// +--------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, stallD, is_branchD, redirectD, flush;
  logic [31:0] redirect_pcD, flush_pc;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [31:0] instrD, pcD;
  logic        validD, adelD, delayslotD;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(BASE)) dut (
    .clk(clk), .rst(rst), .stallD(stallD), .is_branchD(is_branchD),
    .redirectD(redirectD), .redirect_pcD(redirect_pcD), .flush(flush), .flush_pc(flush_pc),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .instrD(instrD), .pcD(pcD), .validD(validD), .adelD(adelD),
    .delayslotD(delayslotD)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ds;
    logic        adel;
  } exp_t;

  exp_t        sb[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          addr_lat = 2, data_lat = 1;
  int          br_wait, br_dcnt;
  logic        br_busy;
  logic [31:0] br_addr;
  logic        del_flag;
  logic [31:0] del_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic ds, input logic adel);
    exp_t e;
    e.pc = pc; e.instr = adel ? 32'h0 : mem_word(pc); e.ds = ds; e.adel = adel;
    sb.push_back(e);
  endtask

  // One clock: sample D-side after the edge, then update the bridge at the falling edge.
  task automatic step();
    logic s_stall, s_flush, s_rst;
    exp_t e;
    @(posedge clk);
    s_stall = stallD; s_flush = flush; s_rst = rst;
    #1;
    del_flag = 1'b0;
    if (!s_rst && !s_flush && !s_stall && validD) begin
      del_flag = 1'b1;
      del_pc   = pcD;
      if (sb.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL unexpected_delivery: got pcD %h, nothing expected", pcD);
      end else begin
        e = sb.pop_front();
        chk("pcD", pcD, e.pc);
        chk("instrD", instrD, e.instr);
        chk("delayslotD", {31'b0, delayslotD}, {31'b0, e.ds});
        chk("adelD", {31'b0, adelD}, {31'b0, e.adel});
      end
    end
    if (s_flush && !s_rst) chk("flush_bubble", {31'b0, validD}, 32'd0);
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    if (rst) begin
      br_busy = 1'b0; br_wait = 0; br_dcnt = 0;
    end else if (br_busy) begin
      if (br_dcnt <= 1) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_word(br_addr);
        br_busy      = 1'b0;
      end else br_dcnt--;
    end else if (inst_req) begin
      chk("req_aligned", {30'b0, inst_addr[1:0]}, 32'd0);
      br_wait++;
      if (br_wait >= addr_lat) begin
        inst_addr_ok = 1'b1;
        br_busy = 1'b1; br_dcnt = data_lat; br_addr = inst_addr; br_wait = 0;
      end
    end
  endtask

  task automatic wait_deliv(input logic [31:0] pc, input int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      step();
      if (del_flag && del_pc == pc) got = 1'b1;
    end
    if (!got) begin
      vec_cnt++; err_cnt++;
      $display("FAIL wait_deliv: pc %h not delivered within %0d cycles", pc, max);
    end
  endtask

  task automatic wait_data(input logic [31:0] addr, input int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      step();
      if (inst_data_ok && br_addr == addr) got = 1'b1;
    end
    if (!got) begin
      vec_cnt++; err_cnt++;
      $display("FAIL wait_data: no response for %h within %0d cycles", addr, max);
    end
  endtask

  task automatic wait_req(input logic [31:0] addr, input int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      step();
      if (inst_req) got = 1'b1;
    end
    if (got) chk("req_addr", inst_addr, addr);
    else begin
      vec_cnt++; err_cnt++;
      $display("FAIL wait_req: no request within %0d cycles", max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stallD = 1'b0; is_branchD = 1'b0; redirectD = 1'b0; flush = 1'b0;
    redirect_pcD = '0; flush_pc = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    br_busy = 1'b0; br_wait = 0; br_dcnt = 0; br_addr = '0;
    del_flag = 1'b0; del_pc = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_validD", {31'b0, validD}, 32'd0);
      chk("rst_instrD", instrD, 32'd0);
      chk("rst_pcD", pcD, 32'd0);
      chk("rst_inst_req", {31'b0, inst_req}, 32'd0);
    end
    chk("inst_wr", {31'b0, inst_wr}, 32'd0);
    chk("inst_size", {30'b0, inst_size}, 32'd2);
    chk("inst_wdata", inst_wdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req", {31'b0, inst_req}, 32'd1);
    chk("first_addr", inst_addr, BASE);

    // Sequential fetch, then a decode stall while the third word returns.
    push_exp(BASE + 32'h0, 1'b0, 1'b0);
    push_exp(BASE + 32'h4, 1'b0, 1'b0);
    push_exp(BASE + 32'h8, 1'b0, 1'b0);
    wait_data(BASE + 32'h8, 40);
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_req", {31'b0, inst_req}, 32'd0);
      chk("stall_validD", {31'b0, validD}, 32'd0);
      chk("stall_instrD", instrD, 32'd0);
    end
    stallD = 1'b0;
    push_exp(BASE + 32'hC, 1'b0, 1'b0);
    push_exp(BASE + 32'h10, 1'b0, 1'b0);
    wait_deliv(BASE + 32'h8, 10);
    chk("post_stall_req", {31'b0, inst_req}, 32'd1);
    chk("post_stall_addr", inst_addr, BASE + 32'hC);

    // Taken branch at _0010: delay slot _0014 then target _0100.
    wait_deliv(BASE + 32'h10, 20);
    is_branchD = 1'b1; redirectD = 1'b1; redirect_pcD = BASE + 32'h100;
    push_exp(BASE + 32'h14, 1'b1, 1'b0);
    push_exp(BASE + 32'h100, 1'b0, 1'b0);
    push_exp(BASE + 32'h104, 1'b0, 1'b0);
    step();
    is_branchD = 1'b0; redirectD = 1'b0;
    wait_deliv(BASE + 32'h104, 30);

    // Flush while waiting for data of _0108.
    data_lat = 3;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        step();
        if (br_busy && br_addr == BASE + 32'h108 && !inst_addr_ok && !inst_data_ok) hit = 1'b1;
      end
      chk("reach_wait_108", {31'b0, hit}, 32'd1);
    end
    flush = 1'b1; flush_pc = BASE + 32'h380;
    push_exp(BASE + 32'h380, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    wait_req(BASE + 32'h380, 20);
    data_lat = 1;
    wait_deliv(BASE + 32'h380, 20);

    // Branch to a misaligned target: delay slot, then an address-error word.
    is_branchD = 1'b1; redirectD = 1'b1; redirect_pcD = BASE + 32'h102;
    push_exp(BASE + 32'h384, 1'b1, 1'b0);
    push_exp(BASE + 32'h102, 1'b0, 1'b1);
    step();
    is_branchD = 1'b0; redirectD = 1'b0;
    wait_deliv(BASE + 32'h102, 20);
    chk("no_req_misaligned", {31'b0, inst_req}, 32'd0);
    flush = 1'b1; flush_pc = BASE + 32'h200;
    push_exp(BASE + 32'h200, 1'b0, 1'b0);
    step();
    flush = 1'b0;

    // Flush while a stalled word sits in the hold buffer.
    wait_data(BASE + 32'h204, 30);
    stallD = 1'b1;
    step();
    step();
    flush = 1'b1; flush_pc = BASE + 32'h300;
    push_exp(BASE + 32'h300, 1'b0, 1'b0);
    step();
    flush = 1'b0; stallD = 1'b0;
    wait_deliv(BASE + 32'h300, 20);

    // Flush in REQ before address accept retargets in place.
    flush = 1'b1; flush_pc = BASE + 32'h400;
    step();
    flush = 1'b0;
    chk("retarget_req", {31'b0, inst_req}, 32'd1);
    chk("retarget_addr", inst_addr, BASE + 32'h400);
    push_exp(BASE + 32'h400, 1'b0, 1'b0);
    wait_deliv(BASE + 32'h400, 20);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
